// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch redirect flushes,
// multi-cycle data-memory freezes, plus saturating perf counters and a sticky timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 64,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           idRs1Addr,
  input  logic [3:0]           idRs2Addr,
  input  logic                 idUsesRs1,
  input  logic                 idUsesRs2,
  input  logic                 exIsLoad,
  input  logic                 exRegWrEn,
  input  logic [3:0]           exRegWrAddr,
  input  logic                 exBranchTaken,
  input  logic                 memReq,
  input  logic                 memReady,
  output logic                 pcWrEn,
  output logic                 ifidWrEn,
  output logic                 ifidFlush,
  output logic                 idexWrEn,
  output logic                 idexFlush,
  output logic                 exmemWrEn,
  output logic                 memwbWrEn,
  output logic                 memwbFlush,
  output logic [CNT_WIDTH-1:0] stallCnt,
  output logic [CNT_WIDTH-1:0] flushCnt,
  output logic                 memErr
);

  typedef enum logic [0:0] {StRun, StLoadStall} state_e;

  localparam bit                   MultiBubble = (LOAD_USE_BUBBLES > 1);
  localparam logic [2:0]           BubbleInit  = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [7:0]           TimeoutVal  = 8'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CntMax      = '1;

  state_e                stateQ, stateD;
  logic [2:0]            bubbleQ, bubbleD;
  logic [7:0]            waitQ, waitD;
  logic [CNT_WIDTH-1:0]  stallCntQ, stallCntD;
  logic [CNT_WIDTH-1:0]  flushCntQ, flushCntD;
  logic                  memErrQ, memErrD;

  logic memWait;
  logic branchFlush;
  logic loadUse;
  logic stallCycle;

  assign memWait     = memReq & ~memReady;
  assign branchFlush = exBranchTaken & ~memWait;
  assign loadUse     = exIsLoad & exRegWrEn &
                       ((idUsesRs1 & (idRs1Addr == exRegWrAddr)) |
                        (idUsesRs2 & (idRs2Addr == exRegWrAddr)));
  // A LOAD_STALL keeps bubbling regardless of the current loadUse term.
  assign stallCycle  = ~memWait & ~branchFlush & ((stateQ == StLoadStall) | loadUse);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ    <= StRun;
      bubbleQ   <= '0;
      waitQ     <= '0;
      stallCntQ <= '0;
      flushCntQ <= '0;
      memErrQ   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      bubbleQ   <= bubbleD;
      waitQ     <= waitD;
      stallCntQ <= stallCntD;
      flushCntQ <= flushCntD;
      memErrQ   <= memErrD;
    end
  end

  // Next-state
  always_comb begin
    stateD  = stateQ;
    bubbleD = bubbleQ;
    if (memWait) begin
      // Freeze: bubble sequence resumes once memory completes.
      stateD  = stateQ;
      bubbleD = bubbleQ;
    end else if (branchFlush) begin
      stateD  = StRun;
      bubbleD = '0;
    end else begin
      unique case (stateQ)
        StRun: begin
          if (loadUse && MultiBubble) begin
            stateD  = StLoadStall;
            bubbleD = BubbleInit;
          end
        end
        StLoadStall: begin
          bubbleD = bubbleQ - 3'd1;
          if (bubbleQ <= 3'd1) begin
            stateD = StRun;
          end
        end
        default: begin
          stateD  = StRun;
          bubbleD = '0;
        end
      endcase
    end
  end

  // Wait-timeout tracking and performance counters
  always_comb begin
    waitD     = '0;
    memErrD   = memErrQ | (waitQ == TimeoutVal);
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    if (memWait) begin
      waitD = (waitQ == TimeoutVal) ? waitQ : waitQ + 8'd1;
    end
    if (!pcWrEn && (stallCntQ != CntMax)) begin
      stallCntD = stallCntQ + 1'b1;
    end
    if (branchFlush && (flushCntQ != CntMax)) begin
      flushCntD = flushCntQ + 1'b1;
    end
  end

  // Outputs; reset forces the no-hazard pattern
  always_comb begin
    pcWrEn     = 1'b1;
    ifidWrEn   = 1'b1;
    ifidFlush  = 1'b0;
    idexWrEn   = 1'b1;
    idexFlush  = 1'b0;
    exmemWrEn  = 1'b1;
    memwbWrEn  = 1'b1;
    memwbFlush = 1'b0;
    if (reset) begin
      if (memWait) begin
        // MEM/WB takes a bubble so the stalled MEM result is not written back twice.
        pcWrEn     = 1'b0;
        ifidWrEn   = 1'b0;
        idexWrEn   = 1'b0;
        exmemWrEn  = 1'b0;
        memwbFlush = 1'b1;
      end else if (branchFlush) begin
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
      end else if (stallCycle) begin
        pcWrEn    = 1'b0;
        ifidWrEn  = 1'b0;
        idexFlush = 1'b1;
      end
    end
  end

  assign stallCnt = stallCntQ;
  assign flushCnt = flushCntQ;
  assign memErr   = memErrQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two DUT configurations share randomized/directed stimulus; a
// cycle-level behavioural model queues expected outputs, a monitor compares at negedge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic [3:0] idRs1Addr = '0, idRs2Addr = '0, exRegWrAddr = '0;
  logic       idUsesRs1 = 0, idUsesRs2 = 0, exIsLoad = 0, exRegWrEn = 0;
  logic       exBranchTaken = 0, memReq = 0, memReady = 0;

  logic pcA, ifidWrA, ifidFlA, idexWrA, idexFlA, exmemWrA, memwbWrA, memwbFlA, errA;
  logic pcB, ifidWrB, ifidFlB, idexWrB, idexFlB, exmemWrB, memwbWrB, memwbFlB, errB;
  logic [15:0] stallA, flushA;
  logic [3:0]  stallB, flushB;

  pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(64), .CNT_WIDTH(16)) dutA (
    .clk(clk), .reset(reset), .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .exIsLoad(exIsLoad), .exRegWrEn(exRegWrEn),
    .exRegWrAddr(exRegWrAddr), .exBranchTaken(exBranchTaken), .memReq(memReq),
    .memReady(memReady), .pcWrEn(pcA), .ifidWrEn(ifidWrA), .ifidFlush(ifidFlA),
    .idexWrEn(idexWrA), .idexFlush(idexFlA), .exmemWrEn(exmemWrA), .memwbWrEn(memwbWrA),
    .memwbFlush(memwbFlA), .stallCnt(stallA), .flushCnt(flushA), .memErr(errA)
  );

  pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(8), .CNT_WIDTH(4)) dutB (
    .clk(clk), .reset(reset), .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .exIsLoad(exIsLoad), .exRegWrEn(exRegWrEn),
    .exRegWrAddr(exRegWrAddr), .exBranchTaken(exBranchTaken), .memReq(memReq),
    .memReady(memReady), .pcWrEn(pcB), .ifidWrEn(ifidWrB), .ifidFlush(ifidFlB),
    .idexWrEn(idexWrB), .idexFlush(idexFlB), .exmemWrEn(exmemWrB), .memwbWrEn(memwbWrB),
    .memwbFlush(memwbFlB), .stallCnt(stallB), .flushCnt(flushB), .memErr(errB)
  );

  logic [7:0] ctlA, ctlB;
  assign ctlA = {pcA, ifidWrA, ifidFlA, idexWrA, idexFlA, exmemWrA, memwbWrA, memwbFlA};
  assign ctlB = {pcB, ifidWrB, ifidFlB, idexWrB, idexFlB, exmemWrB, memwbWrB, memwbFlB};

  // {pc, ifidWr, ifidFlush, idexWr, idexFlush, exmemWr, memwbWr, memwbFlush}
  localparam logic [7:0] CtlNormal = 8'b1101_0110;
  localparam logic [7:0] CtlFreeze = 8'b0000_0011;
  localparam logic [7:0] CtlFlush  = 8'b1111_1110;
  localparam logic [7:0] CtlStall  = 8'b0001_1110;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [15:0] st;
    logic [15:0] fl;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int failures = 0;

  // Reference model state: bubbles still owed, consecutive waits, counters, sticky error
  int  mBub[2]  = '{1, 3};
  int  mTmo[2]  = '{64, 8};
  int  mMax[2]  = '{65535, 15};
  int  owed[2]  = '{0, 0};
  int  waits[2] = '{0, 0};
  int  st[2]    = '{0, 0};
  int  fl[2]    = '{0, 0};
  bit  err[2]   = '{0, 0};

  task automatic drive(input logic rst, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] wa, input logic u1, input logic u2, input logic ld,
                       input logic wr, input logic br, input logic mq, input logic mr);
    logic wt, lu;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; idRs1Addr = a1; idRs2Addr = a2; exRegWrAddr = wa;
    idUsesRs1 = u1; idUsesRs2 = u2; exIsLoad = ld; exRegWrEn = wr;
    exBranchTaken = br; memReq = mq; memReady = mr;
    wt = mq & ~mr;
    lu = ld & wr & ((u1 & (a1 == wa)) | (u2 & (a2 == wa)));
    for (int m = 0; m < 2; m++) begin
      e.st  = 16'(st[m]);
      e.fl  = 16'(fl[m]);
      e.err = err[m];
      if (!rst) begin
        e.ctl = CtlNormal;
        owed[m] = 0; waits[m] = 0; st[m] = 0; fl[m] = 0; err[m] = 0;
      end else begin
        if (wt) begin
          e.ctl = CtlFreeze;
        end else if (br) begin
          e.ctl = CtlFlush;
          owed[m] = 0;
        end else if (owed[m] > 0) begin
          e.ctl = CtlStall;
          owed[m] = owed[m] - 1;
        end else if (lu) begin
          e.ctl = CtlStall;
          owed[m] = mBub[m] - 1;
        end else begin
          e.ctl = CtlNormal;
        end
        if (waits[m] == mTmo[m]) err[m] = 1'b1;
        waits[m] = wt ? ((waits[m] < mTmo[m]) ? waits[m] + 1 : waits[m]) : 0;
        if (!e.ctl[7] && st[m] < mMax[m]) st[m] = st[m] + 1;
        if (e.ctl == CtlFlush && fl[m] < mMax[m]) fl[m] = fl[m] + 1;
      end
      if (m == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadUse1();
    drive(1, 4'd0, 4'd5, 4'd5, 0, 1, 1, 1, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int dut, input logic [15:0] act,
                     input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", name, dut, $time, act, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an expectation is queued
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("ctl", 0, {8'b0, ctlA}, {8'b0, e.ctl});
        chk("stallCnt", 0, stallA, e.st);
        chk("flushCnt", 0, flushA, e.fl);
        chk("memErr", 0, {15'b0, errA}, {15'b0, e.err});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("ctl", 1, {8'b0, ctlB}, {8'b0, e.ctl});
        chk("stallCnt", 1, {12'b0, stallB}, e.st);
        chk("flushCnt", 1, {12'b0, flushB}, e.fl);
        chk("memErr", 1, {15'b0, errB}, {15'b0, e.err});
      end
    end
  end

  initial begin
    int   stuck;
    logic rst, mq, mr;
    stuck = 0;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(10);
    // single load-use hazard: 1 bubble on A, 3 on B
    loadUse1();
    idle(5);
    // branch taken in the second bubble cycle
    loadUse1();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // 4-cycle memory wait with a held taken branch, then completion
    repeat (4) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(3);
    // long wait trips the timeout on B; error stays until reset
    repeat (10) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // flush counter saturation on the 4-bit instance
    repeat (20) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // reset in the middle of a LOAD_STALL
    loadUse1();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) != 0);
      if (stuck == 0 && $urandom_range(0, 79) == 0) stuck = int'($urandom_range(6, 14));
      if (stuck > 0) begin
        mq = 1'b1; mr = 1'b0; stuck--;
      end else begin
        mq = 1'($urandom_range(0, 1));
        mr = ($urandom_range(0, 3) != 0);
      end
      drive(rst, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), mq, mr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives the per-stage write enables and bubble-insert (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC write enable.
- Resolves three hazard classes: load-use dependence, taken branch/jump redirect, and multi-cycle data-memory access.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error flag.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 64, maximum consecutive wait cycles on one memory access before memErr is set (2..255).
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low.
- idRs1Addr  in  4  ID-stage source register 1.
- idRs2Addr  in  4  ID-stage source register 2.
- idUsesRs1  in  1  ID instruction reads rs1.
- idUsesRs2  in  1  ID instruction reads rs2.
- exIsLoad  in  1  EX-stage instruction is a load.
- exRegWrEn  in  1  EX-stage instruction writes the register file.
- exRegWrAddr  in  4  EX-stage destination register.
- exBranchTaken  in  1  EX-stage redirect resolved taken this cycle.
- memReq  in  1  MEM-stage instruction is a load or store.
- memReady  in  1  data memory completes the access this cycle.
- pcWrEn  out  1  PC update enable.
- ifidWrEn  out  1  IF/ID write enable.
- ifidFlush  out  1  IF/ID loads a bubble.
- idexWrEn  out  1  ID/EX write enable.
- idexFlush  out  1  ID/EX loads a bubble.
- exmemWrEn  out  1  EX/MEM write enable.
- memwbWrEn  out  1  MEM/WB write enable.
- memwbFlush  out  1  MEM/WB loads a bubble.
- stallCnt  out  CNT_WIDTH  cycles with pcWrEn=0, saturating.
- flushCnt  out  CNT_WIDTH  taken-branch flushes, saturating.
- memErr  out  1  sticky memory-timeout error.

Behaviour:
- Reset: sampled on the rising clk edge while reset==0.
  - state=RUN, bubble counter=0, wait counter=0, stallCnt=0, flushCnt=0, memErr=0.
  - Control outputs are combinational and take their RUN/no-hazard values during reset: all WrEn=1, all Flush=0.
  - Reset asserted mid-stall or mid-wait abandons the sequence with no residual bubbles.
- Hazard terms (combinational):
  - loadUse = exIsLoad & exRegWrEn & ((idUsesRs1 & idRs1Addr==exRegWrAddr) | (idUsesRs2 & idRs2Addr==exRegWrAddr)).
  - Register 0 is not special-cased.
- Priority, per cycle: memory wait > branch flush > load-use > normal.
- Memory wait (memReq & !memReady), any state:
  - pcWrEn, ifidWrEn, idexWrEn, exmemWrEn = 0; memwbWrEn=1 with memwbFlush=1, so no duplicate writeback.
  - ifidFlush=idexFlush=0; exBranchTaken and loadUse are ignored that cycle. EX holds, so they re-present after the wait.
  - Wait counter increments; cleared in any cycle without a wait.
  - When the counter reaches MEM_TIMEOUT, memErr sets and stays set until reset. The freeze continues; memErr does not alter control outputs.
  - An active LOAD_STALL bubble counter is frozen, not decremented.
- Branch flush (exBranchTaken, no memory wait):
  - pcWrEn=1, ifidFlush=1, idexFlush=1; all WrEn=1.
  - Overrides loadUse and any LOAD_STALL in progress; state goes to RUN, bubble counter cleared.
  - flushCnt += 1, saturating at all-ones.
- Load-use (loadUse, no wait, no branch), in RUN:
  - pcWrEn=0, ifidWrEn=0, idexFlush=1, other WrEn=1.
  - If LOAD_USE_BUBBLES>1: enter LOAD_STALL with counter=LOAD_USE_BUBBLES-1.
- LOAD_STALL state:
  - Same outputs as load-use regardless of loadUse; counter decrements each non-wait cycle.
  - Returns to RUN in the cycle after the counter reaches 0; the last bubble is issued on the counter==1 cycle.
- Normal: all WrEn=1, all Flush=0.
- stallCnt: increments in every cycle with pcWrEn==0 and reset==1, saturating at 2^CNT_WIDTH-1.
- Latency: all control outputs are combinational, same cycle as their inputs. Counters and memErr update at the next edge.

Test Plan:
- Reset then idle (all inputs 0) for 10 cycles -> all WrEn=1, all Flush=0, stallCnt=0, flushCnt=0, memErr=0.
- exIsLoad=1, exRegWrEn=1, exRegWrAddr=5, idUsesRs2=1, idRs2Addr=5 for 1 cycle -> pcWrEn=0, ifidWrEn=0, idexFlush=1 for exactly 1 cycle; stallCnt=1. Repeat with LOAD_USE_BUBBLES=3 -> 3 bubble cycles, stallCnt=3.
- LOAD_USE_BUBBLES=3; exBranchTaken=1 in the 2nd bubble cycle -> that cycle ifidFlush=idexFlush=1 and pcWrEn=1; next cycle normal; flushCnt=1, stallCnt=1.
- memReq=1, memReady=0 for 4 cycles, then memReady=1 with exBranchTaken=1 held throughout -> 4 freeze cycles with memwbFlush=1 and no flush; then 1 flush cycle; stallCnt=4, flushCnt=1.
- MEM_TIMEOUT=8; memReq=1, memReady=0 for 10 cycles -> memErr=1 from the 9th edge onward; still 1 after memReady=1; cleared only by reset=0.
- CNT_WIDTH=4; 20 consecutive taken branches -> flushCnt saturates at 15. Assert reset=0 during a LOAD_STALL -> next cycle outputs normal, counters 0.
